// File: rtl/dir_button_ctrl.sv
// Direction button front end: sync + debounce four buttons, resolve conflicts, emit
// vsync-aligned direction and move strobes with hold-to-accelerate. Option macro: BTN_DIAG_EN.
module dir_button_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 400000,
   parameter int unsigned SLOW_DIV        = 4,
   parameter int unsigned HOLD_FRAMES     = 30
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_left,
   input  logic btn_right,
   input  logic vsync,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic move_en,
   output logic moving
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int unsigned KW   = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam int unsigned PhW  = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;

   localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [KW-1:0]   KHold  = KW'(HOLD_FRAMES);
   localparam logic [PhW-1:0]  PhLast = PhW'(SLOW_DIV - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSlow,
      StFast
   } state_e;

   // Bit order everywhere: {right, left, down, up}
   logic [3:0]            w_btn_raw;
   logic [3:0]            r_sync1;
   logic [3:0]            r_sync2;
   logic [3:0]            r_stable;
   logic [3:0]            w_stable_nxt;
   logic [3:0][CntW-1:0]  r_db_cnt;
   logic [3:0][CntW-1:0]  w_db_cnt_nxt;

   logic                  r_vsync_q;
   logic                  w_vsync_rise;
   logic [3:0]            w_res;
   logic [3:0]            w_cand;

   state_e                r_state;
   state_e                w_state_nxt;
   logic [3:0]            r_vec;
   logic [3:0]            w_vec_nxt;
   logic [KW-1:0]         r_k;
   logic [KW-1:0]         w_k_nxt;
   logic [PhW-1:0]        r_phase;
   logic [PhW-1:0]        w_phase_nxt;
   logic                  r_move_en;
   logic                  w_move_en_nxt;

   assign w_btn_raw = {btn_right, btn_left, btn_down, btn_up};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Counter tracks consecutive disagreeing cycles; the flip lands on the last one.
   always_comb begin
      w_stable_nxt = r_stable;
      w_db_cnt_nxt = '0;
      for (int i = 0; i < 4; i++) begin
         if (r_sync2[i] != r_stable[i]) begin
            if (r_db_cnt[i] == DbLast) begin
               w_stable_nxt[i] = r_sync2[i];
            end else begin
               w_db_cnt_nxt[i] = r_db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable <= '0;
         r_db_cnt <= '0;
      end else begin
         r_stable <= w_stable_nxt;
         r_db_cnt <= w_db_cnt_nxt;
      end
   end

   always_comb begin
      w_res = r_stable;
      if (r_stable[0] & r_stable[1]) begin
         w_res[1:0] = 2'b00;
      end
      if (r_stable[2] & r_stable[3]) begin
         w_res[3:2] = 2'b00;
      end
   end

`ifdef BTN_DIAG_EN
   assign w_cand = w_res;
`else
   assign w_cand = (|w_res[1:0]) ? {2'b00, w_res[1:0]} : w_res;
`endif

   assign w_vsync_rise = vsync & ~r_vsync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_q <= 1'b0;
      end else begin
         r_vsync_q <= vsync;
      end
   end

   // r_phase mirrors k mod SLOW_DIV so no divider is needed.
   always_comb begin
      w_state_nxt   = r_state;
      w_vec_nxt     = r_vec;
      w_k_nxt       = r_k;
      w_phase_nxt   = r_phase;
      w_move_en_nxt = r_move_en;
      if (w_vsync_rise) begin
         if (w_cand == 4'b0000) begin
            w_state_nxt   = StIdle;
            w_vec_nxt     = 4'b0000;
            w_k_nxt       = '0;
            w_phase_nxt   = '0;
            w_move_en_nxt = 1'b0;
         end else if ((r_state == StIdle) || (w_cand != r_vec)) begin
            w_state_nxt   = StSlow;
            w_vec_nxt     = w_cand;
            w_k_nxt       = '0;
            w_phase_nxt   = '0;
            w_move_en_nxt = 1'b1;
         end else begin
            case (r_state)
               StSlow: begin
                  w_k_nxt     = r_k + 1'b1;
                  w_phase_nxt = (r_phase == PhLast) ? '0 : r_phase + 1'b1;
                  if (w_k_nxt == KHold) begin
                     w_state_nxt   = StFast;
                     w_move_en_nxt = 1'b1;
                  end else begin
                     w_move_en_nxt = (w_phase_nxt == '0);
                  end
               end
               StFast: begin
                  w_move_en_nxt = 1'b1;
               end
               default: begin
                  w_state_nxt   = StIdle;
                  w_move_en_nxt = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_vec     <= 4'b0000;
         r_k       <= '0;
         r_phase   <= '0;
         r_move_en <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_vec     <= w_vec_nxt;
         r_k       <= w_k_nxt;
         r_phase   <= w_phase_nxt;
         r_move_en <= w_move_en_nxt;
      end
   end

   assign up      = r_vec[0];
   assign down    = r_vec[1];
   assign left    = r_vec[2];
   assign right   = r_vec[3];
   assign move_en = r_move_en;
   assign moving  = (r_state != StIdle);

endmodule

// File: tb/tb_dir_button_ctrl.sv
// Bench for dir_button_ctrl: frame-level reference model checked every cycle, plus
// directed scenarios with literal expectations. Honours BTN_DIAG_EN like the design.
module tb_dir_button_ctrl;

   localparam int unsigned DB    = 4;
   localparam int unsigned SD    = 4;
   localparam int unsigned HF    = 8;
   localparam int unsigned FRAME = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_up = 1'b0;
   logic btn_down = 1'b0;
   logic btn_left = 1'b0;
   logic btn_right = 1'b0;
   logic vsync = 1'b0;
   logic up, down, left, right, move_en, moving;
   logic [5:0] w_dut;

   int n_cmp = 0;
   int n_err = 0;
   int frame_cnt = 0;

   // Reference model state
   logic [3:0] m_s1, m_s2, m_stable, m_vec;
   int         m_run [4];
   logic       m_vs_prev, m_move;
   int         m_mode, m_k;

   logic [0:11] hold_pat = 12'b1000_1000_1111;
   logic [3:0]  sweep [20] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h6, 4'h9, 4'hA, 4'h3, 4'hC,
                               4'hF, 4'h1, 4'h1, 4'h0, 4'h7, 4'hB, 4'hD, 4'hE, 4'h4, 4'h0};

   dir_button_ctrl #(
      .DEBOUNCE_CYCLES (DB),
      .SLOW_DIV        (SD),
      .HOLD_FRAMES     (HF)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .vsync     (vsync),
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .move_en   (move_en),
      .moving    (moving)
   );

   assign w_dut = {moving, move_en, right, left, down, up};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (moving,move_en,right,left,down,up) t=%0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] model_resolve(input logic [3:0] s);
      logic u, d, l, r;
      u = s[0] && !s[1];
      d = s[1] && !s[0];
      l = s[2] && !s[3];
      r = s[3] && !s[2];
`ifndef BTN_DIAG_EN
      if (u || d) begin
         l = 1'b0;
         r = 1'b0;
      end
`endif
      return {r, l, d, u};
   endfunction

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      m_stable = '0;
      m_vec = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_vs_prev = 1'b0;
      m_move = 1'b0;
      m_mode = 0;
      m_k = 0;
   endtask

   // One clock edge of the spec: frame decision uses pre-edge stable values.
   task automatic model_step();
      logic [3:0] cand;
      logic       rise;
      cand = model_resolve(m_stable);
      rise = vsync && !m_vs_prev;
      if (rise) begin
         frame_cnt++;
         if (cand == 4'h0) begin
            m_mode = 0;
            m_k = 0;
            m_vec = 4'h0;
            m_move = 1'b0;
         end else if (m_mode == 0 || cand != m_vec) begin
            m_mode = 1;
            m_k = 0;
            m_vec = cand;
            m_move = 1'b1;
         end else if (m_mode == 1) begin
            m_k++;
            if (m_k >= HF) begin
               m_mode = 2;
               m_move = 1'b1;
            end else begin
               m_move = ((m_k % SD) == 0);
            end
         end else begin
            m_move = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_stable[i] = m_s2[i];
               m_run[i] = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = {btn_right, btn_left, btn_down, btn_up};
      m_vs_prev = vsync;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst_n) model_reset();
         else model_step();
         @(negedge clk);
         if (!rst_n) model_reset();
         check("cycle", w_dut, {(m_mode != 0), m_move, m_vec});
      end
   end

   initial begin
      forever begin
         for (int c = 0; c < FRAME; c++) begin
            @(posedge clk);
            #2;
            vsync = (c < 4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic [3:0] b);
      @(posedge clk);
      #2;
      {btn_right, btn_left, btn_down, btn_up} = b;
   endtask

   task automatic wait_rise();
      int start;
      int n;
      start = frame_cnt;
      n = 0;
      while (frame_cnt == start && n < 3 * FRAME) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (frame_cnt == start) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_rise: got no vsync rise, required one within %0d cycles", 3 * FRAME);
      end
   endtask

   initial begin
      {btn_right, btn_left, btn_down, btn_up} = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold", w_dut, 6'b00_0000);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      check("post_rst", w_dut, 6'b00_0000);
      wait_rise();
      wait_rise();
      check("all_high_conflict", w_dut, 6'b00_0000);

      drive(4'h0);
      wait_rise();
      wait_rise();
      for (int i = 0; i < 8; i++) begin
         drive((i % 2 == 0) ? 4'h1 : 4'h0);
         @(posedge clk);
      end
      wait_rise();
      check("toggle_quiet", w_dut, 6'b00_0000);

      drive(4'h1);
      for (int f = 0; f < 12; f++) begin
         wait_rise();
         check($sformatf("hold_f%0d", f), w_dut, {1'b1, hold_pat[f], 4'b0001});
      end

      drive(4'h3);
      wait_rise();
      check("conflict_ud", w_dut, 6'b00_0000);
      drive(4'h7);
      wait_rise();
      check("conflict_add_left", w_dut, 6'b11_0100);
      drive(4'h0);
      wait_rise();
      wait_rise();
      check("release", w_dut, 6'b00_0000);

      drive(4'h1);
      for (int f = 0; f < 10; f++) wait_rise();
      check("fast_reached", w_dut, 6'b11_0001);
      drive(4'h9);
      for (int f = 0; f < 4; f++) begin
         wait_rise();
`ifdef BTN_DIAG_EN
         check($sformatf("dir_chg_f%0d", f), w_dut, {1'b1, (f == 0), 4'b1001});
`else
         check($sformatf("dir_chg_f%0d", f), w_dut, 6'b11_0001);
`endif
      end

      drive(4'h1);
      wait_rise();
      wait_rise();
      drive(4'h5);
      repeat (2) @(posedge clk);
      drive(4'h1);
      wait_rise();
      wait_rise();
      check("glitch_ignored", {moving, 1'b0, right, left, down, up}, 6'b10_0001);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid", w_dut, 6'b00_0000);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      check("rst_requal", w_dut, 6'b00_0000);
      wait_rise();
      wait_rise();
      check("rst_requal_up", {moving, 1'b0, right, left, down, up}, 6'b10_0001);

      for (int s = 0; s < 20; s++) begin
         drive(sweep[s]);
         for (int f = 0; f < 5; f++) wait_rise();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
